// File: rtl/piso_serializer_pkg.sv
// Shared types and helpers for the parallel-in/serial-out transmitter.
package piso_serializer_pkg;

  // Frame FSM encoding: IDLE waits for a word, SHIFT drives frame bits.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Bit-counter width; a one-bit counter is the floor for tiny words.
  function automatic int cnt_bits(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Bit-position counter for the serializer: clears on frame start/end,
// advances once per shifted bit, and flags the last bit position.
module piso_bit_counter
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam int CW = cnt_bits(WIDTH);

  logic [CW-1:0] count;

  // Count bit positions; clear wins, and the count parks at WIDTH-1.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !tc) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: accepts a word through a valid/ready
// handshake and shifts it out one bit per shift_en tick with frame strobes.
// A new word can be taken on the last-bit tick for gap-free frames.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             frame_done,
  output logic             busy
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg;
  logic             last_bit;
  logic             last_tick;
  logic             accept;
  logic             head_bit;

  assign accept = load_valid && load_ready;

  piso_bit_counter #(
    .WIDTH(WIDTH)
  ) u_bit_counter (
    .CLK (CLK),
    .RST (RST),
    .clr (accept || last_tick),
    .inc ((state == ST_SHIFT) && shift_en),
    .tc  (last_bit)
  );

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake/strobe decode.
  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt  = state;
    load_ready = 1'b0;
    frame_done = 1'b0;
    last_tick  = 1'b0;
    case (state)
      ST_IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (shift_en && last_bit) begin
          last_tick  = 1'b1;
          frame_done = 1'b1;
          load_ready = 1'b1;
          if (!load_valid) begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Shift register: load on acceptance, move the next bit to the head per tick.
  // NOTE: the datapath register is reset too, so a dropped frame leaves no residue.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      shreg <= '0;
    end else if (accept) begin
      shreg <= din;
    end else if ((state == ST_SHIFT) && shift_en && !last_bit) begin
      shreg <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
    end
  end

  // One-cycle frame_start pulse in the first cycle of every frame.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= accept;
    end
  end

  assign head_bit   = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
  assign sout       = (state == ST_SHIFT) ? head_bit : IDLE_LEVEL;
  assign sout_valid = (state == ST_SHIFT);
  assign busy       = (state == ST_SHIFT);

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in/serial-out transmitter built on the team's D flip-flop style.
- Accepts a WIDTH-bit word through a valid/ready load handshake and shifts it out one bit per `shift_en` tick, with frame strobes.
- Acts as the transmit end feeding the serial-in/parallel-out capture path.
- Sits between a parallel data source and a single-wire serial link.

Parameters:
- WIDTH, 8, word length in bits (2..32).
- MSB_FIRST, 1, 1 = shift MSB first, 0 = LSB first.
- IDLE_LEVEL, 1'b1, level driven on `sout` when no frame is active.

Ports:
- CLK  input  1  single clock; all state updates on its rising edge.
- RST  input  1  reset, asynchronous, active-low.
- din  input  WIDTH  parallel word to transmit.
- load_valid  input  1  source offers `din`.
- load_ready  output  1  serializer can accept a word this cycle.
- shift_en  input  1  bit-rate tick; one bit period ends per tick.
- sout  output  1  serial data.
- sout_valid  output  1  high while a frame bit is on `sout`.
- frame_start  output  1  one-cycle pulse in the first cycle of a frame.
- frame_done  output  1  one-cycle pulse on the tick that ends the last bit.
- busy  output  1  high in SHIFT state.

Behaviour:
- Reset (RST low, asynchronous) forces the following, regardless of CLK:
  - state = IDLE, shift register = 0, bit counter = 0.
  - `sout` = IDLE_LEVEL, `sout_valid` = 0, `frame_start` = 0, `frame_done` = 0, `busy` = 0.
  - A frame in progress is dropped with no `frame_done`.
  - Reset deassertion takes effect at the next CLK edge.
- FSM states are IDLE and SHIFT.
- IDLE:
  - `load_ready` = 1.
  - When `load_valid` is high at the clock edge: capture `din`, counter = 0, go to SHIFT, pulse `frame_start` in the next cycle.
  - `shift_en` is ignored.
- SHIFT:
  - `sout` = current head bit (MSB if MSB_FIRST=1, else LSB), registered.
  - `sout_valid` = 1 and `busy` = 1.
  - The bit is held until `shift_en`. On `shift_en` with counter < WIDTH-1, shift the register by one toward the head and increment the counter.
- Last bit (counter == WIDTH-1 and `shift_en` high):
  - `frame_done` pulses for that cycle.
  - `load_ready` = 1 combinationally in that same cycle only.
  - If `load_valid` is also high: capture the new `din`, stay in SHIFT, reset the counter, pulse `frame_start` next cycle. This gives back-to-back frames with no idle gap.
  - Otherwise return to IDLE, with `sout` = IDLE_LEVEL next cycle.
- `load_valid` in SHIFT outside the last-bit tick: not accepted, `load_ready` = 0. The source must hold `din` and `load_valid`.
- `din` is sampled only on the accepting edge; later changes have no effect on the frame.
- Latency: the first bit appears on `sout` one cycle after acceptance. Each bit lasts exactly one `shift_en` interval. A frame spans WIDTH ticks.
- `shift_en` high on every cycle gives 1 bit per clock. `shift_en` asserted in the acceptance cycle does not count toward the new frame.
- Counter width is clog2(WIDTH). The counter never wraps past WIDTH-1.

Decomposition:
- No shared package needed.
- Keep a local state encoding constant (IDLE = 1'b0, SHIFT = 1'b1).
- One natural sub-module, `piso_bit_counter`: clear/increment, terminal-count flag at WIDTH-1, same CLK/RST.
- Shift register and FSM stay in the top module.

Test Plan:
- Reset: hold RST low with `load_valid`=1 and `din`=8'hFF.
  -> `sout`=1, `sout_valid`=0, `busy`=0, `load_ready`=1 after release, no capture during reset.
- Single frame, MSB_FIRST=1: load 8'hA5 with `shift_en` every cycle.
  -> `sout` sequence 1,0,1,0,0,1,0,1.
  -> `frame_start` 1 cycle after acceptance, `frame_done` on the 8th tick, then `sout`=IDLE_LEVEL.
- LSB_FIRST build (MSB_FIRST=0): load 8'h3C with `shift_en` every 4th cycle.
  -> `sout` sequence 0,0,1,1,1,1,0,0, each bit held 4 cycles.
- Back-to-back: 8'hF0 then 8'h0F, second `load_valid` held throughout.
  -> second word accepted only on the last-bit tick.
  -> 16 contiguous valid bits, `sout_valid` never drops, two `frame_done` pulses.
- Mid-frame reset: assert RST low asynchronously after the 3rd bit of 8'hC3 (between clock edges).
  -> outputs clear immediately, no `frame_done`.
  -> a new load after release starts a full 8-bit frame from bit 0.
- Stall: in SHIFT, hold `shift_en`=0 for 20 cycles.
  -> `sout` stable, counter unchanged, `load_ready`=0, `frame_done` absent.
